// File: rtl/saturation_ext.sv
// saturation_ext: RGB saturation filter with per-frame coefficient shadowing.
//
// Luma is y = round(ycoe0*R + ycoe1*G + ycoe2*B), and each channel becomes
// y + (c - y)*saturation, rounded and clamped to the pixel range.
// Grayscale and bypass modes share the same 9-cycle pipeline, so latency does
// not depend on the mode.
//
// Ports
//   clk, rst_n                       pixel clock, asynchronous active-low reset
//   mode_i                           00/11 saturate, 01 bypass, 10 grayscale
//   saturation_i                     saturation gain, COE_FRACTION_WIDTH fraction bits
//   ycoe0_i/ycoe1_i/ycoe2_i          luma weights for R/G/B
//   di_i, de_i, hs_i, vs_i           input pixel {B,G,R} and timing
//   do_o, de_o, hs_o, vs_o           output pixel and timing, 9 clk later
//   cfg_applied_o                    single-cycle pulse when the shadow set loads
//   clip_cnt_o                       clipped-pixel count of the previous frame
module saturation_ext #(
    parameter int PIXEL_WIDTH        = 8,
    parameter int COE_WIDTH          = 9,
    parameter int COE_FRACTION_WIDTH = 6,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode_i,
    input  logic [COE_WIDTH-1:0]       saturation_i,
    input  logic [COE_WIDTH-1:0]       ycoe0_i,
    input  logic [COE_WIDTH-1:0]       ycoe1_i,
    input  logic [COE_WIDTH-1:0]       ycoe2_i,
    input  logic [3*PIXEL_WIDTH-1:0]   di_i,
    input  logic                       de_i,
    input  logic                       hs_i,
    input  logic                       vs_i,
    output logic [3*PIXEL_WIDTH-1:0]   do_o,
    output logic                       de_o,
    output logic                       hs_o,
    output logic                       vs_o,
    output logic                       cfg_applied_o,
    output logic [CNT_WIDTH-1:0]       clip_cnt_o
);

    localparam int PW    = PIXEL_WIDTH;
    localparam int CW    = COE_WIDTH;
    localparam int F     = COE_FRACTION_WIDTH;
    localparam int PRODW = PW + CW;
    localparam int YSW   = PW + CW + 2;
    localparam int TW    = PW + CW + 3;

    localparam logic [1:0]           MODE_BYPASS = 2'b01;
    localparam logic [1:0]           MODE_GRAY   = 2'b10;
    localparam logic [CW-1:0]        SAT_ONE     = CW'(1 << F);
    localparam logic [YSW-1:0]       HALF_Y      = YSW'(1 << (F - 1));
    localparam logic [TW-1:0]        HALF_T      = TW'(1 << (F - 1));
    localparam logic [YSW-1:0]       MAX_Y       = YSW'((1 << PW) - 1);
    localparam logic signed [TW-1:0] MAX_T       = TW'((1 << PW) - 1);

    function automatic logic [PW-1:0] luma_round(input logic [YSW-1:0] s);
        logic [YSW-1:0] r;
        r = (s + HALF_Y) >> F;
        return (r > MAX_Y) ? '1 : r[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] clamp_pix(input logic signed [TW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > MAX_T)
            return '1;
        else
            return v[PW-1:0];
    endfunction

    function automatic logic out_of_range(input logic signed [TW-1:0] v);
        return (v < 0) || (v > MAX_T);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] cnt_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic inc);
        return (inc && (c != '1)) ? c + 1'b1 : c;
    endfunction

    // Shadow (active) configuration, reloaded only on a vs_i rising edge
    logic            vs_in_q;
    logic [1:0]      sh_mode;
    logic [CW-1:0]   sh_sat;
    logic [CW-1:0]   sh_yc [3];
    logic            cfg_load;
    logic [1:0]      eff_mode;
    logic [CW-1:0]   eff_sat;
    logic [CW-1:0]   eff_yc [3];

    assign cfg_load = vs_i & ~vs_in_q;

    // The pixel entering on the load cycle already sees the new set; every
    // pixel carries its own copy down the pipe so later reloads cannot touch it.
    always_comb begin
        eff_mode  = cfg_load ? mode_i       : sh_mode;
        eff_sat   = cfg_load ? saturation_i : sh_sat;
        eff_yc[0] = cfg_load ? ycoe0_i      : sh_yc[0];
        eff_yc[1] = cfg_load ? ycoe1_i      : sh_yc[1];
        eff_yc[2] = cfg_load ? ycoe2_i      : sh_yc[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_in_q       <= 1'b0;
            cfg_applied_o <= 1'b0;
            sh_mode       <= MODE_BYPASS;
            sh_sat        <= SAT_ONE;
            for (int i = 0; i < 3; i++) sh_yc[i] <= '0;
        end else begin
            vs_in_q       <= vs_i;
            cfg_applied_o <= cfg_load;
            if (cfg_load) begin
                sh_mode <= mode_i;
                sh_sat  <= saturation_i;
                sh_yc[0] <= ycoe0_i;
                sh_yc[1] <= ycoe1_i;
                sh_yc[2] <= ycoe2_i;
            end
        end
    end

    logic [3*PW-1:0]        pix_p0, pix_p1, pix_p2, pix_p3, pix_p4, pix_p5, pix_p6;
    logic                   vld_p0, vld_p1, vld_p2, vld_p3, vld_p4, vld_p5, vld_p6, vld_p7;
    logic [1:0]             sync_p0, sync_p1, sync_p2, sync_p3, sync_p4, sync_p5, sync_p6, sync_p7;
    logic [1:0]             mode_p0, mode_p1, mode_p2, mode_p3, mode_p4, mode_p5, mode_p6;
    logic [CW-1:0]          sat_p0, sat_p1, sat_p2, sat_p3;
    logic [CW-1:0]          yc_p0 [3];
    logic [PRODW-1:0]       yprod_p1 [3];
    logic [YSW-1:0]         ysum_p2;
    logic [PW-1:0]          y_p3, y_p4, y_p5, y_p6;
    logic [PRODW-1:0]       csat_p4 [3];
    logic [PRODW-1:0]       ysat_p4;
    logic signed [TW-1:0]   t_p5 [3];
    logic signed [TW-1:0]   v_p6 [3];
    logic [3*PW-1:0]        res_p7;
    logic                   clip_p7, clip_p8;
    logic [3*PW-1:0]        res_c;
    logic                   clip_c;

    // Final mode select; only the saturate path can report clipping
    always_comb begin
        res_c  = '0;
        clip_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            res_c[i*PW +: PW] = clamp_pix(v_p6[i]);
            clip_c            = clip_c | out_of_range(v_p6[i]);
        end
        if (mode_p6 == MODE_BYPASS) begin
            res_c  = pix_p6;
            clip_c = 1'b0;
        end else if (mode_p6 == MODE_GRAY) begin
            res_c  = {3{y_p6}};
            clip_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {pix_p0, pix_p1, pix_p2, pix_p3, pix_p4, pix_p5, pix_p6} <= '0;
            {vld_p0, vld_p1, vld_p2, vld_p3, vld_p4, vld_p5, vld_p6, vld_p7} <= '0;
            {sync_p0, sync_p1, sync_p2, sync_p3, sync_p4, sync_p5, sync_p6, sync_p7} <= '0;
            {mode_p0, mode_p1, mode_p2, mode_p3, mode_p4, mode_p5, mode_p6} <= '0;
            {sat_p0, sat_p1, sat_p2, sat_p3} <= '0;
            {ysum_p2, ysat_p4} <= '0;
            {y_p3, y_p4, y_p5, y_p6} <= '0;
            {res_p7, clip_p7, clip_p8} <= '0;
            {do_o, de_o, hs_o, vs_o} <= '0;
            for (int i = 0; i < 3; i++) begin
                yc_p0[i]    <= '0;
                yprod_p1[i] <= '0;
                csat_p4[i]  <= '0;
                t_p5[i]     <= '0;
                v_p6[i]     <= '0;
            end
        end else begin
            // p0: capture pixel, timing and the configuration it will use
            pix_p0  <= di_i;
            vld_p0  <= de_i;
            sync_p0 <= {vs_i, hs_i};
            mode_p0 <= eff_mode;
            sat_p0  <= eff_sat;
            for (int i = 0; i < 3; i++) yc_p0[i] <= eff_yc[i];

            // p1: luma weight products
            for (int i = 0; i < 3; i++)
                yprod_p1[i] <= PRODW'(yc_p0[i]) * PRODW'(pix_p0[i*PW +: PW]);
            {pix_p1, vld_p1, sync_p1, mode_p1, sat_p1} <= {pix_p0, vld_p0, sync_p0, mode_p0, sat_p0};

            // p2: luma sum
            ysum_p2 <= YSW'(yprod_p1[0]) + YSW'(yprod_p1[1]) + YSW'(yprod_p1[2]);
            {pix_p2, vld_p2, sync_p2, mode_p2, sat_p2} <= {pix_p1, vld_p1, sync_p1, mode_p1, sat_p1};

            // p3: rounded, clamped luma
            y_p3 <= luma_round(ysum_p2);
            {pix_p3, vld_p3, sync_p3, mode_p3, sat_p3} <= {pix_p2, vld_p2, sync_p2, mode_p2, sat_p2};

            // p4: gain products c*sat and y*sat
            for (int i = 0; i < 3; i++)
                csat_p4[i] <= PRODW'(pix_p3[i*PW +: PW]) * PRODW'(sat_p3);
            ysat_p4 <= PRODW'(y_p3) * PRODW'(sat_p3);
            {pix_p4, vld_p4, sync_p4, mode_p4, y_p4} <= {pix_p3, vld_p3, sync_p3, mode_p3, y_p3};

            // p5: t = y*2^F + c*sat - y*sat + half; modular TW-bit math is the
            // two's-complement signed result since the true range fits TW bits
            for (int i = 0; i < 3; i++)
                t_p5[i] <= $signed((TW'(y_p4) << F) + TW'(csat_p4[i]) - TW'(ysat_p4) + HALF_T);
            {pix_p5, vld_p5, sync_p5, mode_p5, y_p5} <= {pix_p4, vld_p4, sync_p4, mode_p4, y_p4};

            // p6: floor division by 2^F
            for (int i = 0; i < 3; i++)
                v_p6[i] <= t_p5[i] >>> F;
            {pix_p6, vld_p6, sync_p6, mode_p6, y_p6} <= {pix_p5, vld_p5, sync_p5, mode_p5, y_p5};

            // p7: clamp and mode select
            res_p7  <= res_c;
            clip_p7 <= clip_c;
            vld_p7  <= vld_p6;
            sync_p7 <= sync_p6;

            // p8: output registers
            do_o    <= res_p7;
            de_o    <= vld_p7;
            hs_o    <= sync_p7[0];
            vs_o    <= sync_p7[1];
            clip_p8 <= clip_p7;
        end
    end

    logic                  vs_o_q;
    logic                  clip_inc;
    logic [CNT_WIDTH-1:0]  clip_acc;

    assign clip_inc = clip_p8 & de_o;

    // The frame boundary cycle's own pixel is included in the published count
    // and also seeds the new frame's accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_o_q     <= 1'b0;
            clip_acc   <= '0;
            clip_cnt_o <= '0;
        end else begin
            vs_o_q <= vs_o;
            if (vs_o && !vs_o_q) begin
                clip_cnt_o <= cnt_add(clip_acc, clip_inc);
                clip_acc   <= CNT_WIDTH'(clip_inc);
            end else begin
                clip_acc <= cnt_add(clip_acc, clip_inc);
            end
        end
    end

endmodule

// File: tb/tb_saturation_ext.sv
// Directed bench for saturation_ext: a behavioural model with its own shadow
// register and clip counter pushes expected outputs into a queue as each
// input cycle is driven; they are popped and compared 9 cycles later.
module tb_saturation_ext;
    localparam int PW = 8;
    localparam int CW = 9;
    localparam int CNTW = 16;

    logic              clk;
    logic              rst_n;
    logic [1:0]        mode_i;
    logic [CW-1:0]     saturation_i, ycoe0_i, ycoe1_i, ycoe2_i;
    logic [3*PW-1:0]   di_i;
    logic              de_i, hs_i, vs_i;
    logic [3*PW-1:0]   do_o;
    logic              de_o, hs_o, vs_o, cfg_applied_o;
    logic [CNTW-1:0]   clip_cnt_o;

    saturation_ext dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .saturation_i(saturation_i),
        .ycoe0_i(ycoe0_i), .ycoe1_i(ycoe1_i), .ycoe2_i(ycoe2_i),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .cfg_applied_o(cfg_applied_o), .clip_cnt_o(clip_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [23:0] px;
        logic        de;
        logic        hs;
        logic        vs;
        logic        clip;
    } exp_t;

    exp_t        sb[$];
    exp_t        prev_e;
    int          cyc, passed, total;
    logic [1:0]  m_mode;
    int          m_sat, m_y0, m_y1, m_y2;
    logic        m_vsin_q, m_vso_q;
    int          m_acc, m_cnt_out;

    localparam logic [23:0] RGB_A  = {8'd50, 8'd100, 8'd200};
    localparam logic [23:0] GRAY_A = {8'd124, 8'd124, 8'd124};
    localparam logic [23:0] SAT2_A = {8'd0, 8'd76, 8'd255};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model(input logic [1:0] md, input int s, input int k0, input int k1,
                         input int k2, input logic [23:0] rgb,
                         output logic [23:0] o, output logic clip);
        int c [3];
        int y, t, v;
        c[0] = int'(rgb[7:0]);
        c[1] = int'(rgb[15:8]);
        c[2] = int'(rgb[23:16]);
        y = (k0 * c[0] + k1 * c[1] + k2 * c[2] + 32) >>> 6;
        if (y > 255) y = 255;
        o = '0;
        clip = 1'b0;
        if (md == 2'b01) begin
            o = rgb;
        end else if (md == 2'b10) begin
            o = {8'(y), 8'(y), 8'(y)};
        end else begin
            for (int i = 0; i < 3; i++) begin
                t = y * 64 + c[i] * s - y * s + 32;
                v = t >>> 6;
                if (v < 0 || v > 255) clip = 1'b1;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                o[i*8 +: 8] = 8'(v);
            end
        end
    endtask

    task automatic model_reset();
        sb.delete();
        prev_e    = '{0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        m_mode    = 2'b01;
        m_sat     = 64;
        m_y0      = 0;
        m_y1      = 0;
        m_y2      = 0;
        m_vsin_q  = 1'b0;
        m_vso_q   = 1'b0;
        m_acc     = 0;
        m_cnt_out = 0;
    endtask

    task automatic tick();
        exp_t       e, cur;
        logic       load;
        logic [1:0] em;
        int         es, e0, e1, e2, inc;
        load = vs_i && !m_vsin_q;
        if (load) begin
            em = mode_i; es = int'(saturation_i);
            e0 = int'(ycoe0_i); e1 = int'(ycoe1_i); e2 = int'(ycoe2_i);
        end else begin
            em = m_mode; es = m_sat; e0 = m_y0; e1 = m_y1; e2 = m_y2;
        end
        model(em, es, e0, e1, e2, di_i, e.px, e.clip);
        e.de  = de_i;
        e.hs  = hs_i;
        e.vs  = vs_i;
        e.due = cyc + 9;
        sb.push_back(e);
        if (load) begin
            m_mode = em; m_sat = es; m_y0 = e0; m_y1 = e1; m_y2 = e2;
        end
        m_vsin_q = vs_i;

        @(posedge clk);
        #1;
        cyc = cyc + 1;

        chk("cfg_applied", 32'(cfg_applied_o), 32'(load));

        inc = (prev_e.clip && prev_e.de) ? 1 : 0;
        if (prev_e.vs && !m_vso_q) begin
            m_cnt_out = (m_acc + inc > 65535) ? 65535 : m_acc + inc;
            m_acc     = inc;
        end else begin
            m_acc = (m_acc + inc > 65535) ? 65535 : m_acc + inc;
        end
        m_vso_q = prev_e.vs;
        chk("clip_cnt", 32'(clip_cnt_o), 32'(m_cnt_out));

        if (sb.size() > 0 && sb[0].due == cyc) cur = sb.pop_front();
        else cur = '{0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        chk("do", 32'(do_o), 32'(cur.px));
        chk("de", 32'(de_o), 32'(cur.de));
        chk("hs", 32'(hs_o), 32'(cur.hs));
        chk("vs", 32'(vs_o), 32'(cur.vs));
        prev_e = cur;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vs_pulse();
        de_i = 1'b0;
        vs_i = 1'b1;
        tick();
        tick();
        vs_i = 1'b0;
        tick();
    endtask

    task automatic line(input int n);
        de_i = 1'b1;
        hs_i = 1'b0;
        run(n);
        de_i = 1'b0;
        hs_i = 1'b1;
        tick();
        hs_i = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] md, input int s, input int k0, input int k1,
                           input int k2);
        mode_i       = md;
        saturation_i = CW'(s);
        ycoe0_i      = CW'(k0);
        ycoe1_i      = CW'(k1);
        ycoe2_i      = CW'(k2);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        set_cfg(2'b00, 0, 0, 0, 0);
        di_i = RGB_A;
        de_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_do", 32'(do_o), 32'h0);
        chk("rst_de", 32'(de_o), 32'h0);
        chk("rst_vs", 32'(vs_o), 32'h0);
        chk("rst_cfg", 32'(cfg_applied_o), 32'h0);
        chk("rst_clip", 32'(clip_cnt_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // before any vs edge the shadow set is bypass
        line(4);
        run(10);
        chk("dflt_bypass", 32'(do_o), 32'(RGB_A));

        // unity saturation passes pixels unchanged
        set_cfg(2'b00, 64, 0, 0, 0);
        vs_pulse();
        line(6);
        run(10);
        chk("sat64", 32'(do_o), 32'(RGB_A));

        // grayscale
        set_cfg(2'b10, 64, 19, 38, 7);
        vs_pulse();
        line(6);
        run(10);
        chk("gray", 32'(do_o), 32'(GRAY_A));

        // zero saturation gives luma on every channel
        set_cfg(2'b00, 0, 19, 38, 7);
        vs_pulse();
        line(4);
        run(10);
        chk("sat0", 32'(do_o), 32'(GRAY_A));

        // double saturation clips high and low
        set_cfg(2'b00, 128, 19, 38, 7);
        vs_pulse();
        line(3);
        run(10);
        chk("sat128", 32'(do_o), 32'(SAT2_A));

        // mode 11 behaves as saturate
        set_cfg(2'b11, 128, 19, 38, 7);
        vs_pulse();
        line(2);
        run(10);
        chk("mode11", 32'(do_o), 32'(SAT2_A));

        // frame of 10 clipped pixels, then a clean frame
        set_cfg(2'b00, 128, 19, 38, 7);
        vs_pulse();
        line(10);
        run(3);
        saturation_i = CW'(64);
        vs_pulse();
        run(12);
        chk("clip10", 32'(clip_cnt_o), 32'd10);
        line(10);
        run(3);
        vs_pulse();
        run(12);
        chk("clip0", 32'(clip_cnt_o), 32'd0);

        // mid-frame gain change waits for the next vs edge
        saturation_i = CW'(0);
        line(5);
        run(10);
        chk("shadow_hold", 32'(do_o), 32'(RGB_A));
        vs_pulse();
        line(2);
        run(10);
        chk("shadow_new", 32'(do_o), 32'(GRAY_A));

        // luma saturates at MAX
        set_cfg(2'b10, 64, 64, 64, 64);
        di_i = 24'hFFFFFF;
        vs_pulse();
        line(2);
        run(10);
        chk("luma_max", 32'(do_o), 32'hFFFFFF);

        // randomised frames checked against the model
        for (int f = 0; f < 4; f++) begin
            set_cfg(2'($urandom_range(0, 3)), int'($urandom_range(0, 300)),
                    int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 40)));
            vs_pulse();
            for (int p = 0; p < 20; p++) begin
                di_i = 24'($urandom);
                de_i = 1'($urandom_range(0, 1));
                tick();
            end
            de_i = 1'b0;
        end

        // build a nonzero count, then reset mid-line
        set_cfg(2'b00, 128, 19, 38, 7);
        di_i = RGB_A;
        vs_pulse();
        line(5);
        run(2);
        vs_pulse();
        run(12);
        chk("clip5", 32'(clip_cnt_o), 32'd5);
        de_i = 1'b1;
        run(12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_do", 32'(do_o), 32'h0);
        chk("arst_de", 32'(de_o), 32'h0);
        chk("arst_clip", 32'(clip_cnt_o), 32'h0);
        de_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        line(3);
        run(10);
        chk("arst_bypass", 32'(do_o), 32'(RGB_A));
        vs_pulse();
        line(1);
        run(10);
        chk("arst_sat", 32'(do_o), 32'(SAT2_A));
        run(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
